// File: rtl/note_lane_engine.sv
// Falling-note sprite engine: slot table, frame advance, key judgement,
// scoring and per-pixel sprite lookup for the palette mux.
module note_lane_engine #(
  parameter int NUM_SLOTS     = 8,
  parameter int NUM_LANES     = 4,
  parameter int LANE_WIDTH    = 80,
  parameter int SPRITE_SIZE   = 50,
  parameter int SCREEN_HEIGHT = 480,
  parameter int HIT_Y         = 400,
  parameter int HIT_WINDOW    = 16,
  parameter int SPEED_W       = 3,
  localparam int LW = $clog2(NUM_LANES),
  localparam int CW = $clog2(NUM_SLOTS+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [SPEED_W-1:0] speed,
  input  logic               spawn_valid,
  input  logic [LW-1:0]      spawn_lane,
  input  logic [1:0]         spawn_color,
  output logic               spawn_ready,
  input  logic               key_valid,
  input  logic [LW-1:0]      key_lane,
  input  logic [9:0]         x,
  input  logic [8:0]         y,
  output logic               pix_hit,
  output logic [1:0]         pix_color,
  output logic [11:0]        pix_addr,
  output logic               hit_pulse,
  output logic [LW-1:0]      hit_lane,
  output logic               miss_pulse,
  output logic [15:0]        score,
  output logic [CW-1:0]      active_count
);

  localparam int HALF = SPRITE_SIZE / 2;
  localparam int WLO  = (HIT_Y > HIT_WINDOW) ? HIT_Y - HIT_WINDOW : 0;
  localparam int WHI  = HIT_Y + HIT_WINDOW;

  logic [NUM_SLOTS-1:0] vld, vld_n;
  logic [LW-1:0]        lane   [NUM_SLOTS];
  logic [LW-1:0]        lane_n [NUM_SLOTS];
  logic [9:0]           ypos   [NUM_SLOTS];
  logic [9:0]           ypos_n [NUM_SLOTS];
  logic [1:0]           col    [NUM_SLOTS];
  logic [1:0]           col_n  [NUM_SLOTS];

  logic          hit_any, retired, spawn_fire, free_found;
  logic [CW-1:0] cnt_n;
  logic [10:0]   sum, centre;

  assign spawn_ready = !reset && (|(~vld));
  assign spawn_fire  = spawn_valid && (|(~vld));

  always_comb begin
    vld_n      = vld;
    lane_n     = lane;
    ypos_n     = ypos;
    col_n      = col;
    hit_any    = 1'b0;
    retired    = 1'b0;
    free_found = 1'b0;
    cnt_n      = '0;
    sum        = '0;
    centre     = '0;
    // a judged slot is neither advanced nor counted as a miss
    for (int i = 0; i < NUM_SLOTS; i++) begin
      centre = 11'(ypos[i]) + 11'(HALF);
      sum    = 11'(ypos[i]) + 11'(speed);
      if (!hit_any && key_valid && vld[i] && lane[i] == key_lane &&
          int'(centre) >= WLO && int'(centre) <= WHI) begin
        hit_any  = 1'b1;
        vld_n[i] = 1'b0;
      end else if (frame_tick && vld[i]) begin
        if (int'(sum) >= SCREEN_HEIGHT) begin
          vld_n[i] = 1'b0;
          retired  = 1'b1;
        end else begin
          ypos_n[i] = sum[9:0];
        end
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!free_found && !vld[i]) begin
        free_found = 1'b1;
        if (spawn_fire) begin
          vld_n[i]  = 1'b1;
          ypos_n[i] = '0;
          lane_n[i] = spawn_lane;
          col_n[i]  = spawn_color;
        end
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++)
      cnt_n = cnt_n + CW'(vld_n[i]);
  end

  logic        px_hit_n, px_found;
  logic [1:0]  px_col_n;
  logic [11:0] px_addr_n;
  int          ox, oy;

  always_comb begin
    px_hit_n  = 1'b0;
    px_col_n  = '0;
    px_addr_n = '0;
    px_found  = 1'b0;
    ox        = 0;
    oy        = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      ox = int'(lane[i]) * LANE_WIDTH;
      oy = int'(ypos[i]);
      if (!px_found && vld[i] &&
          int'(x) >= ox && int'(x) < ox + SPRITE_SIZE &&
          int'(y) >= oy && int'(y) < oy + SPRITE_SIZE) begin
        px_found  = 1'b1;
        px_hit_n  = 1'b1;
        px_col_n  = col[i];
        px_addr_n = 12'((int'(x) - ox) + (int'(y) - oy) * SPRITE_SIZE);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld          <= '0;
      pix_hit      <= 1'b0;
      pix_color    <= '0;
      pix_addr     <= '0;
      hit_pulse    <= 1'b0;
      hit_lane     <= '0;
      miss_pulse   <= 1'b0;
      score        <= '0;
      active_count <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        lane[i] <= '0;
        ypos[i] <= '0;
        col[i]  <= '0;
      end
    end else begin
      vld          <= vld_n;
      lane         <= lane_n;
      ypos         <= ypos_n;
      col          <= col_n;
      pix_hit      <= px_hit_n;
      pix_color    <= px_col_n;
      pix_addr     <= px_addr_n;
      hit_pulse    <= hit_any;
      miss_pulse   <= retired;
      active_count <= cnt_n;
      if (hit_any) begin
        hit_lane <= key_lane;
        if (score != 16'hFFFF)
          score <= score + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_note_lane_engine.sv
// Random and directed stimulus for note_lane_engine, checked against a
// slot-table reference model kept in plain integer arrays.
module tb_note_lane_engine;

  localparam int NS = 8;

  logic        clk = 0;
  logic        reset = 0;
  logic        frame_tick = 0;
  logic [2:0]  speed = 0;
  logic        spawn_valid = 0;
  logic [1:0]  spawn_lane = 0;
  logic [1:0]  spawn_color = 0;
  logic        spawn_ready;
  logic        key_valid = 0;
  logic [1:0]  key_lane = 0;
  logic [9:0]  x = 0;
  logic [8:0]  y = 0;
  logic        pix_hit;
  logic [1:0]  pix_color;
  logic [11:0] pix_addr;
  logic        hit_pulse;
  logic [1:0]  hit_lane;
  logic        miss_pulse;
  logic [15:0] score;
  logic [3:0]  active_count;

  note_lane_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .speed(speed),
    .spawn_valid(spawn_valid), .spawn_lane(spawn_lane),
    .spawn_color(spawn_color), .spawn_ready(spawn_ready),
    .key_valid(key_valid), .key_lane(key_lane), .x(x), .y(y),
    .pix_hit(pix_hit), .pix_color(pix_color), .pix_addr(pix_addr),
    .hit_pulse(hit_pulse), .hit_lane(hit_lane), .miss_pulse(miss_pulse),
    .score(score), .active_count(active_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int m_vld [NS];
  int m_lane[NS];
  int m_y   [NS];
  int m_col [NS];
  int m_score, m_hl;
  int e_ph, e_pc, e_pa, e_hp, e_miss, e_cnt;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int in_window(input int ty);
    int d;
    d = ty + 25 - 400;
    if (d < 0) d = -d;
    return (d <= 16) ? 1 : 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_vld[i] = 0; m_lane[i] = 0; m_y[i] = 0; m_col[i] = 0;
    end
    m_score = 0;
    m_hl = 0;
  endtask

  task automatic step(input bit sv, input int sl, input int sc,
                      input bit kv, input int kl, input bit ft,
                      input int sp, input int px, input int py);
    int hs, fs, e_ready;
    spawn_valid = sv; spawn_lane = 2'(sl); spawn_color = 2'(sc);
    key_valid = kv; key_lane = 2'(kl);
    frame_tick = ft; speed = 3'(sp);
    x = 10'(px); y = 9'(py);
    e_ready = 0;
    fs = -1;
    for (int i = 0; i < NS; i++)
      if (!m_vld[i]) begin
        e_ready = 1;
        if (fs < 0) fs = i;
      end
    if (!sv) fs = -1;
    #1;
    check("spawn_ready", spawn_ready, e_ready);
    e_ph = 0; e_pc = 0; e_pa = 0;
    for (int i = NS - 1; i >= 0; i--)
      if (m_vld[i] && px >= m_lane[i] * 80 && px < m_lane[i] * 80 + 50 &&
          py >= m_y[i] && py < m_y[i] + 50) begin
        e_ph = 1; e_pc = m_col[i];
        e_pa = (px - m_lane[i] * 80) + (py - m_y[i]) * 50;
      end
    hs = -1;
    if (kv)
      for (int i = 0; i < NS; i++)
        if (hs < 0 && m_vld[i] && m_lane[i] == kl && in_window(m_y[i])) hs = i;
    e_miss = 0;
    if (ft)
      for (int i = 0; i < NS; i++)
        if (m_vld[i] && i != hs) begin
          m_y[i] += sp;
          if (m_y[i] >= 480) begin
            m_vld[i] = 0;
            e_miss = 1;
          end
        end
    e_hp = 0;
    if (hs >= 0) begin
      m_vld[hs] = 0;
      e_hp = 1;
      m_hl = kl;
      if (m_score < 65535) m_score++;
    end
    if (fs >= 0) begin
      m_vld[fs] = 1; m_y[fs] = 0; m_lane[fs] = sl; m_col[fs] = sc;
    end
    e_cnt = 0;
    for (int i = 0; i < NS; i++) e_cnt += m_vld[i];
    @(posedge clk);
    #1;
    check("active_count", active_count, e_cnt);
    check("hit_pulse", hit_pulse, e_hp);
    check("hit_lane", hit_lane, m_hl);
    check("miss_pulse", miss_pulse, e_miss);
    check("score", score, m_score);
    check("pix_hit", pix_hit, e_ph);
    check("pix_color", pix_color, e_pc);
    check("pix_addr", pix_addr, e_pa);
  endtask

  task automatic idle(input int px, input int py);
    step(0, 0, 0, 0, 0, 0, 0, px, py);
  endtask

  task automatic do_reset(input int pre);
    spawn_valid = 0; key_valid = 0; frame_tick = 0;
    #(pre);
    reset = 1;
    #1;
    check("rst_score", score, 0);
    check("rst_active", active_count, 0);
    check("rst_pix_hit", pix_hit, 0);
    check("rst_pix_addr", pix_addr, 0);
    check("rst_hit_pulse", hit_pulse, 0);
    check("rst_hit_lane", hit_lane, 0);
    check("rst_miss", miss_pulse, 0);
    check("rst_ready", spawn_ready, 0);
    #1;
    reset = 0;
    model_clear();
    idle(0, 0);
  endtask

  // spawn one note in lane ln and bring its top edge to ty
  task automatic place(input int ln, input int ty);
    int left;
    step(1, ln, 1, 0, 0, 0, 0, 0, 0);
    left = ty;
    while (left > 0) begin
      step(0, 0, 0, 0, 0, 1, (left >= 7) ? 7 : left, 0, 0);
      left -= (left >= 7) ? 7 : left;
    end
  endtask

  initial begin
    model_clear();
    do_reset(1);

    // basic spawn and pixel queries
    step(1, 2, 3, 0, 0, 0, 0, 0, 0);
    check("one_active", active_count, 1);
    idle(160, 0);
    check("q0_hit", pix_hit, 1);
    check("q0_color", pix_color, 3);
    check("q0_addr", pix_addr, 0);
    idle(209, 49);
    check("q1_addr", pix_addr, 2499);
    idle(210, 49);
    check("q2_hit", pix_hit, 0);

    // fill all slots, drop extra spawn, reuse the hit slot
    do_reset(2);
    for (int i = 0; i < NS; i++) step(1, i % 4, i % 4, 0, 0, 0, 0, 0, 0);
    check("full_ready", spawn_ready, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    check("full_cnt", active_count, 8);
    for (int i = 0; i < 52; i++) step(0, 0, 0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0, 0, 0);
    check("fill_hit", hit_pulse, 1);
    check("fill_cnt", active_count, 7);
    step(1, 2, 2, 0, 0, 0, 0, 0, 0);
    idle(160, 0);
    check("reuse_color", pix_color, 2);

    // walk a note off the bottom
    do_reset(2);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 119; i++) step(0, 0, 0, 0, 0, 1, 4, 0, 0);
    check("pre_miss", miss_pulse, 0);
    step(0, 0, 0, 0, 0, 1, 4, 0, 0);
    check("miss_t120", miss_pulse, 1);
    check("miss_cnt", active_count, 0);
    check("miss_score", score, 0);
    idle(0, 0);
    check("miss_once", miss_pulse, 0);

    // hit window edges
    do_reset(2);
    place(1, 367);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("wrong_lane", hit_pulse, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    check("hit367", hit_pulse, 1);
    check("hit367_score", score, 1);
    do_reset(2);
    place(1, 366);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    check("hit366", hit_pulse, 1);
    do_reset(2);
    place(1, 333);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    check("miss333", hit_pulse, 0);
    do_reset(2);
    place(3, 391);
    step(0, 0, 0, 1, 3, 1, 7, 0, 0);
    check("key_tick_hit", hit_pulse, 1);
    check("key_tick_miss", miss_pulse, 0);

    // random traffic
    do_reset(2);
    for (int c = 0; c < 3000; c++)
      step(($urandom % 3) == 0, $urandom % 4, $urandom % 4,
           ($urandom % 2) == 0, $urandom % 4, ($urandom % 3) == 0,
           $urandom % 8, $urandom % 640, $urandom % 480);

    // asynchronous reset mid-cycle
    do_reset(3);
    idle(0, 0);
    check("post_rst_hit", hit_pulse, 0);
    check("post_rst_miss", miss_pulse, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
